out_fm_tile_scheduler: RTL and testbench



---
 rtl/out_fm_tile_scheduler.sv | 167 ++++++++++++++++
 tb/tb_out_fm_tile_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fm_tile_scheduler.sv
// out_fm_tile_scheduler
// Walks every Tn x Tr x Tc tile of an N x R x C output feature map, column
// innermost, then row, then depth. For each tile it presents the base
// coordinates, pulses the mover's start, waits for the mover's done, pulses
// the mover's counter clean, then advances. A done pulse marks the end.
//
// Optional feature macro: OUT_FM_TILE_PAUSE_EN (adds pause input + PAUSE state)
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            request to process the whole map (IDLE only)
//   done             one-cycle pulse after the last tile is cleaned
//   busy             high in every state except IDLE and FIN
//   tile_start       one-cycle start pulse to the mover
//   tile_done        mover done (level or pulse), sampled in WAIT only
//   tile_clean       one-cycle clean pulse to the mover's tile counter
//   tile_base_n/row/col  current tile base coordinates (CW bits)
//   pause            hold between tiles (OUT_FM_TILE_PAUSE_EN only)
module out_fm_tile_scheduler #(
  parameter int unsigned CW = 32,
  parameter int unsigned N  = 32,
  parameter int unsigned R  = 64,
  parameter int unsigned C  = 32,
  parameter int unsigned Tn = 8,
  parameter int unsigned Tr = 16,
  parameter int unsigned Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic          tile_start,
  input  logic          tile_done,
  output logic          tile_clean,
  output logic [CW-1:0] tile_base_n,
  output logic [CW-1:0] tile_base_row,
  output logic [CW-1:0] tile_base_col
`ifdef OUT_FM_TILE_PAUSE_EN
  ,
  input  logic          pause
`endif
);

  // Compare width: one extra bit so base + step never wraps
  localparam int unsigned XW = CW + 1;

  if (Tn < 1 || Tr < 1 || Tc < 1 || N < 1 || R < 1 || C < 1) begin : g_bad_param
    $error("out_fm_tile_scheduler: all map and tile dimensions must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CLEAN,
    S_FIN
`ifdef OUT_FM_TILE_PAUSE_EN
    ,
    S_PAUSE
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d, row_q, row_d, col_q, col_d;
  logic          done_q, busy_q, tile_start_q, tile_clean_q;

  logic [XW-1:0] n_ext, row_ext, col_ext;
  logic          n_wrap, row_wrap, col_wrap, last_tile;
  logic          advance;

  // Edge detection for each dimension at CW+1 bits
  always_comb begin
    n_ext     = {1'b0, n_q}   + XW'(Tn);
    row_ext   = {1'b0, row_q} + XW'(Tr);
    col_ext   = {1'b0, col_q} + XW'(Tc);
    n_wrap    = (n_ext   >= XW'(N));
    row_wrap  = (row_ext >= XW'(R));
    col_wrap  = (col_ext >= XW'(C));
    last_tile = n_wrap && row_wrap && col_wrap;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (tile_done) state_d = S_CLEAN;
      S_CLEAN: begin
        if (last_tile) begin
          state_d = S_FIN;
        end else begin
          advance = 1'b1;
`ifdef OUT_FM_TILE_PAUSE_EN
          state_d = pause ? S_PAUSE : S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
`ifdef OUT_FM_TILE_PAUSE_EN
      S_PAUSE: if (!pause) state_d = S_ISSUE;
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Base advance: column innermost, then row, then depth; cleared on FIN
  always_comb begin
    n_d   = n_q;
    row_d = row_q;
    col_d = col_q;
    if (advance) begin
      if (col_wrap) begin
        col_d = '0;
        if (row_wrap) begin
          row_d = '0;
          n_d   = n_q + CW'(Tn);
        end else begin
          row_d = row_q + CW'(Tr);
        end
      end else begin
        col_d = col_q + CW'(Tc);
      end
    end
    if (state_d == S_FIN || state_d == S_IDLE) begin
      n_d   = '0;
      row_d = '0;
      col_d = '0;
    end
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      tile_start_q <= 1'b0;
      tile_clean_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      row_q        <= row_d;
      col_q        <= col_d;
      done_q       <= (state_d == S_FIN);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_FIN);
      tile_start_q <= (state_d == S_ISSUE);
      tile_clean_q <= (state_d == S_CLEAN);
    end
  end

  assign done          = done_q;
  assign busy          = busy_q;
  assign tile_start    = tile_start_q;
  assign tile_clean    = tile_clean_q;
  assign tile_base_n   = n_q;
  assign tile_base_row = row_q;
  assign tile_base_col = col_q;

endmodule

// File: tb/tb_out_fm_tile_scheduler.sv
// Testbench for out_fm_tile_scheduler: two instances (4x4x4 map and 4x4x5 map,
// 2x2x2 tiles), each driven by a small mover model.
module tb_out_fm_tile_scheduler;

  localparam int unsigned CW = 32;

  logic          clk;
  logic          rst;
  logic          st   [2];
  logic          td   [2];
  logic          dn   [2];
  logic          bz   [2];
  logic          ts   [2];
  logic          tc   [2];
  logic [CW-1:0] bn   [2];
  logic [CW-1:0] br   [2];
  logic [CW-1:0] bc   [2];
`ifdef OUT_FM_TILE_PAUSE_EN
  logic          p0;
  logic          p1;
`endif

  // Mover model controls
  bit   hold_m   [2];
  bit   glitch_m [2];
  int   gap_exp  [2];
  bit   dl_chk   [2];

  // Monitor state
  int   cyc;
  int   ts_cnt [2];
  int   tc_cnt [2];
  int   dn_cnt [2];
  int   last_ts[2];
  int   seq    [2][16];

  int   total;
  int   bad;

  // Hand-computed base sequences, encoded n*256 + row*16 + col
  int exp4 [16] = '{'h000, 'h002, 'h020, 'h022, 'h200, 'h202, 'h220, 'h222,
                    0, 0, 0, 0, 0, 0, 0, 0};
  int exp5 [16] = '{'h000, 'h002, 'h004, 'h020, 'h022, 'h024,
                    'h200, 'h202, 'h204, 'h220, 'h222, 'h224, 0, 0, 0, 0};

  out_fm_tile_scheduler #(
    .CW(CW), .N(4), .R(4), .C(4), .Tn(2), .Tr(2), .Tc(2)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .done(dn[0]), .busy(bz[0]),
    .tile_start(ts[0]), .tile_done(td[0]), .tile_clean(tc[0]),
    .tile_base_n(bn[0]), .tile_base_row(br[0]), .tile_base_col(bc[0])
`ifdef OUT_FM_TILE_PAUSE_EN
    , .pause(p0)
`endif
  );

  out_fm_tile_scheduler #(
    .CW(CW), .N(4), .R(4), .C(5), .Tn(2), .Tr(2), .Tc(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .done(dn[1]), .busy(bz[1]),
    .tile_start(ts[1]), .tile_done(td[1]), .tile_clean(tc[1]),
    .tile_base_n(bn[1]), .tile_base_row(br[1]), .tile_base_col(bc[1])
`ifdef OUT_FM_TILE_PAUSE_EN
    , .pause(p1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    logic [2:0] cnt;

    // Mover: tile_done during the 5th cycle after tile_start, or held high
    always @(posedge clk) begin
      if (rst)        cnt <= 3'd0;
      else if (ts[g]) cnt <= 3'd5;
      else if (cnt != 3'd0) cnt <= cnt - 3'd1;
    end
    assign td[g] = hold_m[g] | (cnt == 3'd1) | (glitch_m[g] & ts[g]);

    // Observe pulses and bases mid-cycle
    always @(negedge clk) begin
      if (!rst) begin
        if (ts[g]) begin
          if (ts_cnt[g] < 16)
            seq[g][ts_cnt[g]] = int'(bn[g]) * 256 + int'(br[g]) * 16 + int'(bc[g]);
          if (gap_exp[g] != 0 && last_ts[g] >= 0)
            chk("start_gap", cyc - last_ts[g], gap_exp[g]);
          last_ts[g] = cyc;
          ts_cnt[g]++;
        end
        if (tc[g]) tc_cnt[g]++;
        if (dn[g]) begin
          dn_cnt[g]++;
          chk("busy_at_done", bz[g], 0);
          if (dl_chk[g]) chk("done_latency", cyc - last_ts[g], 3);
        end
      end
    end
  end

  task automatic clear_mon(input int d);
    ts_cnt[d]  = 0;
    tc_cnt[d]  = 0;
    dn_cnt[d]  = 0;
    last_ts[d] = -1;
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_busy"}, bz[d], 0);
    chk({tag, "_done"}, dn[d], 0);
    chk({tag, "_tstart"}, ts[d], 0);
    chk({tag, "_tclean"}, tc[d], 0);
    chk({tag, "_bases"}, bn[d] | br[d] | bc[d], 0);
  endtask

  // Full-map run with sequence, count and end-state checks
  task automatic run_map(input int d, input bit hold, input bit glitch,
                         input int nexp, input int gap);
    bit fin;
    clear_mon(d);
    hold_m[d]   = hold;
    glitch_m[d] = glitch;
    gap_exp[d]  = gap;
    dl_chk[d]   = hold;
    pulse_start(d);
    fin = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (dn_cnt[d] != 0) begin
        fin = 1'b1;
        break;
      end
      st[d] = glitch && (i % 11 == 5);
    end
    st[d] = 1'b0;
    chk("run_finished", fin, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("done_pulses", dn_cnt[d], 1);
    chk("tile_starts", ts_cnt[d], nexp);
    chk("tile_cleans", tc_cnt[d], nexp);
    chk_idle(d, "after_run");
    for (int k = 0; k < nexp; k++)
      chk($sformatf("base%0d_%0d", d, k), seq[d][k], (d == 0) ? exp4[k] : exp5[k]);
    hold_m[d]   = 1'b0;
    glitch_m[d] = 1'b0;
    gap_exp[d]  = 0;
    dl_chk[d]   = 1'b0;
  endtask

  initial begin
    bit hit;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; hold_m[d] = 1'b0; glitch_m[d] = 1'b0;
      gap_exp[d] = 0; dl_chk[d] = 1'b0;
      clear_mon(d);
    end
`ifdef OUT_FM_TILE_PAUSE_EN
    p0 = 1'b0;
    p1 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");
    rst = 1'b0;

    // 4x4x4 map, delayed mover: 7 cycles between tile starts
    run_map(0, 1'b0, 1'b0, 8, 7);
    // 4x4x5 map: partial edge column tiles
    run_map(1, 1'b0, 1'b0, 12, 7);
    // tile_done held high: 3-cycle tile cadence, done 3 cycles after last start
    run_map(0, 1'b1, 1'b0, 8, 3);
    // stray start mid-run and tile_done during ISSUE are ignored
    run_map(0, 1'b0, 1'b1, 8, 7);

    // Reset while waiting on tile 3
    clear_mon(0);
    pulse_start(0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (ts_cnt[0] == 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_tile3", hit, 1);
    @(negedge clk);
    chk("tile3_busy_in_wait", bz[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle(0, "mid_reset");
    rst = 1'b0;
    run_map(0, 1'b0, 1'b0, 8, 7);

`ifdef OUT_FM_TILE_PAUSE_EN
    // Pause after tile 1's clean holds off tile 2 with bases already advanced
    clear_mon(0);
    hold_m[0] = 1'b1;
    pulse_start(0);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (tc_cnt[0] == 1) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_clean1", hit, 1);
    p0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("pause_no_start", ts[0], 0);
      chk("pause_busy", bz[0], 1);
      chk("pause_base_col", bc[0], 2);
    end
    p0 = 1'b0;
    @(negedge clk);
    #1;
    chk("resume_start", ts[0], 1);
    chk("resume_base_col", bc[0], 2);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (dn_cnt[0] != 0) begin
        hit = 1'b1;
        break;
      end
    end
    chk("pause_run_finished", hit, 1);
    chk("pause_tile_starts", ts_cnt[0], 8);
    hold_m[0] = 1'b0;
    repeat (3) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
